// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter that serialises N requesters' load/set/clear/hold operations
// onto one shared W-bit register. Each grant lasts one cycle; the write and ack land at its end.
module shared_reg_arbiter #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      req,
  input  logic [2*N-1:0]    op,
  input  logic [W*N-1:0]    wdata,
  output logic [W-1:0]      q,
  output logic [N-1:0]      gnt,
  output logic [N-1:0]      ack,
  output logic [IW-1:0]     owner,
  output logic              busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   rrPtr_q, rrPtr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [N-1:0]    ack_q, ack_d;
  logic [W-1:0]    regVal_q, regVal_d;
  logic [W-1:0]    dataR_q, dataR_d;
  logic [1:0]      opR_q, opR_d;

  logic [N-1:0]    eff;
  logic [IW-1:0]   sel;
  logic [IW-1:0]   cand;
  logic            selValid;

  // The requester being acknowledged right now is masked so a held req cannot win twice in a row.
  assign eff = req & ~ack_q;

  // Scan downward in distance so the closest set bit after rrPtr_q is the last one written.
  always_comb begin
    sel      = '0;
    cand     = '0;
    selValid = 1'b0;
    for (int k = N; k >= 1; k--) begin
      cand = IW'((int'(rrPtr_q) + k) % N);
      if (eff[cand]) begin
        sel      = cand;
        selValid = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rrPtr_d  = rrPtr_q;
    owner_d  = owner_q;
    gnt_d    = '0;
    ack_d    = '0;
    regVal_d = regVal_q;
    opR_d    = opR_q;
    dataR_d  = dataR_q;
    case (state_q)
      IDLE: begin
        if (selValid) begin
          state_d    = GRANT;
          gnt_d[sel] = 1'b1;
          owner_d    = sel;
          opR_d      = op[2*int'(sel) +: 2];
          dataR_d    = wdata[W*int'(sel) +: W];
        end
      end
      GRANT: begin
        // A dropped request aborts without moving the pointer, so that requester keeps its turn.
        state_d = IDLE;
        if (req[owner_q]) begin
          ack_d[owner_q] = 1'b1;
          rrPtr_d        = owner_q;
          case (opR_q)
            2'b00:   regVal_d = dataR_q;
            2'b01:   regVal_d = '1;
            2'b10:   regVal_d = '0;
            default: regVal_d = regVal_q;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      rrPtr_q  <= LAST_IDX;
      owner_q  <= '0;
      gnt_q    <= '0;
      ack_q    <= '0;
      regVal_q <= '0;
      opR_q    <= '0;
      dataR_q  <= '0;
    end else begin
      state_q  <= state_d;
      rrPtr_q  <= rrPtr_d;
      owner_q  <= owner_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      regVal_q <= regVal_d;
      opR_q    <= opR_d;
      dataR_q  <= dataR_d;
    end
  end

  assign q     = regVal_q;
  assign gnt   = gnt_q;
  assign ack   = ack_q;
  assign owner = owner_q;
  assign busy  = (state_q == GRANT);

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed and randomized checks of shared_reg_arbiter against a transaction-level model,
// plus a fixed expected-waveform check of a two-requester instance.
module tb_shared_reg_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req;
  logic [2*N-1:0]   op;
  logic [W*N-1:0]   wdata;
  logic [W-1:0]     q;
  logic [N-1:0]     gnt;
  logic [N-1:0]     ack;
  logic [IW-1:0]    owner;
  logic             busy;

  logic [1:0]       req2;
  logic [3:0]       op2;
  logic [15:0]      wdata2;
  logic [W-1:0]     q2;
  logic [1:0]       gnt2;
  logic [1:0]       ack2;
  logic [0:0]       owner2;
  logic             busy2;

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model state, phrased as "is a transaction in flight and who owns it".
  bit               mInFlight;
  int               mOwner;
  int               mLastServed;
  logic [N-1:0]     mGnt;
  logic [N-1:0]     mAck;
  logic [W-1:0]     mQ;
  logic [W-1:0]     mData;
  logic [1:0]       mOp;

  logic [1:0] g2Exp [9] = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
  logic [1:0] a2Exp [9] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
  logic [7:0] q2Exp [9] = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h96, 8'h96, 8'hFF};
  int  lat1;
  bit  waiting1;
  bit  served1;

  shared_reg_arbiter #(.N(N), .W(W)) dut (
    .clk(clk), .reset(reset), .req(req), .op(op), .wdata(wdata),
    .q(q), .gnt(gnt), .ack(ack), .owner(owner), .busy(busy)
  );

  shared_reg_arbiter #(.N(2), .W(8)) dut2 (
    .clk(clk), .reset(reset), .req(req2), .op(op2), .wdata(wdata2),
    .q(q2), .gnt(gnt2), .ack(ack2), .owner(owner2), .busy(busy2)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mInFlight   = 1'b0;
    mOwner      = 0;
    mLastServed = N - 1;
    mGnt        = '0;
    mAck        = '0;
    mQ          = '0;
    mData       = '0;
    mOp         = 2'b00;
  endtask

  // Predict the effect of the coming clock edge from the inputs currently applied.
  task automatic modelEdge();
    logic [N-1:0] ackNow;
    int winner;
    ackNow = mAck;
    mAck   = '0;
    mGnt   = '0;
    if (mInFlight) begin
      mInFlight = 1'b0;
      if (req[mOwner]) begin
        if (mOp == 2'b00) mQ = mData;
        else if (mOp == 2'b01) mQ = {W{1'b1}};
        else if (mOp == 2'b10) mQ = '0;
        mAck[mOwner] = 1'b1;
        mLastServed  = mOwner;
      end
    end else begin
      winner = -1;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (mLastServed + k) % N;
        if (winner < 0 && req[c] && !ackNow[c]) winner = c;
      end
      if (winner >= 0) begin
        mInFlight    = 1'b1;
        mOwner       = winner;
        mGnt[winner] = 1'b1;
        mOp          = op[2*winner +: 2];
        mData        = wdata[W*winner +: W];
      end
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".q"},     32'(q),     32'(mQ));
    checkOutput({tag, ".gnt"},   32'(gnt),   32'(mGnt));
    checkOutput({tag, ".ack"},   32'(ack),   32'(mAck));
    checkOutput({tag, ".owner"}, 32'(owner), 32'(mOwner));
    checkOutput({tag, ".busy"},  32'(busy),  32'(mInFlight));
  endtask

  task automatic applyStimulus(input string tag);
    modelEdge();
    @(posedge clk);
    #1;
    checkAll(tag);
  endtask

  task automatic applyReset();
    reset = 1'b1;
    modelReset();
    #2;
    reset = 1'b0;
    checkAll("reset");
  endtask

  initial begin
    reset  = 1'b1;
    req    = '0;
    op     = '0;
    wdata  = '0;
    req2   = '0;
    op2    = '0;
    wdata2 = '0;
    modelReset();
    #12;
    checkAll("resetInit");
    reset = 1'b0;
    applyStimulus("idle");

    // Single load from requester 2.
    req[2] = 1'b1;
    op[4 +: 2] = 2'b00;
    wdata[16 +: 8] = 8'hA5;
    applyStimulus("single.grant");
    checkOutput("single.gnt", 32'(gnt), 32'h4);
    applyStimulus("single.ack");
    checkOutput("single.q", 32'(q), 32'hA5);
    req[2] = 1'b0;
    applyStimulus("single.after");
    checkOutput("single.ackOnce", 32'(ack), 32'h0);

    // All four requesting continuously with mixed ops.
    applyReset();
    req   = 4'b1111;
    op    = {2'b11, 2'b00, 2'b10, 2'b01};
    wdata = {8'h00, 8'h3C, 8'h00, 8'h00};
    for (int i = 0; i < 16; i++) applyStimulus("allReq");
    req = '0;
    applyStimulus("allReq.drain");
    applyStimulus("allReq.idle");

    // Abort: requester 1 drops req in GRANT and keeps its turn.
    applyReset();
    req = 4'b0001;
    op  = {2'b00, 2'b00, 2'b00, 2'b01};
    applyStimulus("abort.pre.grant");
    applyStimulus("abort.pre.ack");
    req = 4'b0000;
    applyStimulus("abort.pre.idle");
    req = 4'b0010;
    wdata[8 +: 8] = 8'h77;
    applyStimulus("abort.grant");
    req = 4'b0000;
    applyStimulus("abort.drop");
    checkOutput("abort.noAck", 32'(ack), 32'h0);
    req = 4'b0011;
    applyStimulus("abort.regrant");
    checkOutput("abort.gnt1First", 32'(gnt), 32'h2);
    applyStimulus("abort.ack");
    checkOutput("abort.q", 32'(q), 32'h77);
    req = 4'b0000;
    applyStimulus("abort.idle");

    // Operands latched at the grant edge.
    applyReset();
    req = 4'b0001;
    op  = '0;
    wdata[0 +: 8] = 8'h11;
    applyStimulus("latch.grant");
    wdata[0 +: 8] = 8'h22;
    applyStimulus("latch.ack");
    checkOutput("latch.q", 32'(q), 32'h11);
    req = '0;
    applyStimulus("latch.idle");

    // Reset in the middle of a grant.
    req = 4'b1000;
    op  = {2'b00, 2'b10, 2'b10, 2'b10};
    wdata[24 +: 8] = 8'h5A;
    applyStimulus("midRst.grant3");
    applyStimulus("midRst.ack3");
    checkOutput("midRst.q5A", 32'(q), 32'h5A);
    req = 4'b0001;
    applyStimulus("midRst.grant0");
    #3;
    reset = 1'b1;
    modelReset();
    #1;
    checkAll("midRst.async");
    #1;
    reset = 1'b0;
    req = 4'b1111;
    applyStimulus("midRst.first");
    checkOutput("midRst.gnt0", 32'(gnt), 32'h1);
    applyStimulus("midRst.ack0");

    // Randomized traffic, including aborts and new requests every cycle.
    for (int i = 0; i < 400; i++) begin
      req   = 4'($urandom_range(0, 15));
      op    = 8'($urandom);
      wdata = 32'($urandom);
      applyStimulus("random");
    end
    req = '0;
    applyStimulus("random.drain1");
    applyStimulus("random.drain2");

    // Two-requester instance: requester 0 holds, requester 1 pulses once.
    applyReset();
    req2     = 2'b01;
    op2      = 4'b0001;
    wdata2   = {8'h96, 8'h00};
    lat1     = 0;
    waiting1 = 1'b0;
    served1  = 1'b0;
    for (int e = 0; e < 9; e++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("n2.gnt[%0d]", e + 1), 32'(gnt2), 32'(g2Exp[e]));
      checkOutput($sformatf("n2.ack[%0d]", e + 1), 32'(ack2), 32'(a2Exp[e]));
      checkOutput($sformatf("n2.q[%0d]", e + 1), 32'(q2), 32'(q2Exp[e]));
      checkOutput($sformatf("n2.busy[%0d]", e + 1), 32'(busy2), 32'(|g2Exp[e]));
      if (waiting1) begin
        lat1++;
        if (ack2[1]) begin
          waiting1 = 1'b0;
          served1  = 1'b1;
        end
      end
      if (e == 3) begin
        req2[1]  = 1'b1;
        waiting1 = 1'b1;
      end
      if (e == 6) req2[1] = 1'b0;
    end
    checkOutput("n2.req1Served", 32'(served1), 32'h1);
    checkOutput("n2.req1Within4", 32'(lat1 <= 4), 32'h1);
    req2 = '0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
